// File: rtl/ct_vfdsu_wb_buffer.sv
// Writeback buffer between the vfdsu EX4 stage and the shared vfpu pipex writeback arbiter.
// Holds results in a circular buffer, stalls EX4 when full, and reports completions and sticky fflags.
module ct_vfdsu_wb_buffer #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 64
) (
   input  logic                     forever_cpuclk,
   input  logic                     cpurst_b,
   input  logic                     rtu_yy_xx_flush,
   input  logic                     vfdsu_wb_vld,
   input  logic [DATA_W-1:0]        vfdsu_wb_freg_data,
   input  logic [4:0]               vfdsu_wb_ereg_data,
   input  logic [4:0]               vfdsu_wb_ereg,
   input  logic [6:0]               vfdsu_wb_vreg,
   input  logic [6:0]               vfdsu_wb_iid,
   output logic                     wb_vfdsu_stall,
   input  logic                     wbarb_grnt,
   output logic                     wb_req,
   output logic [DATA_W-1:0]        wb_freg_data,
   output logic [4:0]               wb_ereg_data,
   output logic [4:0]               wb_ereg,
   output logic [6:0]               wb_vreg,
   output logic [6:0]               wb_iid,
   output logic                     wb_cmplt,
   output logic [6:0]               wb_cmplt_iid,
   input  logic                     cp0_fflags_clr,
   output logic [4:0]               wb_fflags,
   output logic [$clog2(DEPTH):0]   wb_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [4:0]        flags;
      logic [4:0]        ereg;
      logic [6:0]        vreg;
      logic [6:0]        iid;
   } entry_t;

   entry_t             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_cmplt;
   logic [6:0]         r_cmplt_iid;
   logic [4:0]         r_fflags;

   entry_t             w_head;
   entry_t             w_new;
   logic               w_full;
   logic               w_req;
   logic               w_push;
   logic               w_pop;

   // Stall comes only from the registered count: a grant on a full buffer frees a slot next cycle.
   assign w_full  = (r_cnt == CNT_W'(DEPTH));
   assign w_req   = (r_cnt != '0);
   assign w_push  = vfdsu_wb_vld & ~w_full & ~rtu_yy_xx_flush;
   assign w_pop   = w_req & wbarb_grnt & ~rtu_yy_xx_flush;
   assign w_head  = r_mem[r_rd_ptr];
   assign w_new   = '{data:  vfdsu_wb_freg_data,
                      flags: vfdsu_wb_ereg_data,
                      ereg:  vfdsu_wb_ereg,
                      vreg:  vfdsu_wb_vreg,
                      iid:   vfdsu_wb_iid};

   // NOTE: entries are reset because the head data outputs must read zero out of reset.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= w_new;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (rtu_yy_xx_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
         else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_cmplt     <= 1'b0;
         r_cmplt_iid <= '0;
      end else begin
         r_cmplt <= w_pop;
         if (w_pop) r_cmplt_iid <= w_head.iid;
      end
   end

   // A clear drops history but a same-cycle retirement still lands its flags.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_fflags <= '0;
      end else if (cp0_fflags_clr) begin
         r_fflags <= w_pop ? w_head.flags : 5'b0;
      end else if (w_pop) begin
         r_fflags <= r_fflags | w_head.flags;
      end
   end

   assign wb_vfdsu_stall = w_full;
   assign wb_req         = w_req;
   assign wb_freg_data   = w_head.data;
   assign wb_ereg_data   = w_head.flags;
   assign wb_ereg        = w_head.ereg;
   assign wb_vreg        = w_head.vreg;
   assign wb_iid         = w_head.iid;
   assign wb_cmplt       = r_cmplt;
   assign wb_cmplt_iid   = r_cmplt_iid;
   assign wb_fflags      = r_fflags;
   assign wb_cnt         = r_cnt;

endmodule

// File: tb/tb_ct_vfdsu_wb_buffer.sv
// Self-checking bench for ct_vfdsu_wb_buffer: directed table, hand sequences and a
// randomized run compared against a queue-based reference model.
module tb_ct_vfdsu_wb_buffer;

   localparam int DEPTH  = 2;
   localparam int DATA_W = 64;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic                forever_cpuclk;
   logic                cpurst_b;
   logic                rtu_yy_xx_flush;
   logic                vfdsu_wb_vld;
   logic [DATA_W-1:0]   vfdsu_wb_freg_data;
   logic [4:0]          vfdsu_wb_ereg_data;
   logic [4:0]          vfdsu_wb_ereg;
   logic [6:0]          vfdsu_wb_vreg;
   logic [6:0]          vfdsu_wb_iid;
   logic                wb_vfdsu_stall;
   logic                wbarb_grnt;
   logic                wb_req;
   logic [DATA_W-1:0]   wb_freg_data;
   logic [4:0]          wb_ereg_data;
   logic [4:0]          wb_ereg;
   logic [6:0]          wb_vreg;
   logic [6:0]          wb_iid;
   logic                wb_cmplt;
   logic [6:0]          wb_cmplt_iid;
   logic                cp0_fflags_clr;
   logic [4:0]          wb_fflags;
   logic [CNT_W-1:0]    wb_cnt;

   ct_vfdsu_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .forever_cpuclk     (forever_cpuclk),
      .cpurst_b           (cpurst_b),
      .rtu_yy_xx_flush    (rtu_yy_xx_flush),
      .vfdsu_wb_vld       (vfdsu_wb_vld),
      .vfdsu_wb_freg_data (vfdsu_wb_freg_data),
      .vfdsu_wb_ereg_data (vfdsu_wb_ereg_data),
      .vfdsu_wb_ereg      (vfdsu_wb_ereg),
      .vfdsu_wb_vreg      (vfdsu_wb_vreg),
      .vfdsu_wb_iid       (vfdsu_wb_iid),
      .wb_vfdsu_stall     (wb_vfdsu_stall),
      .wbarb_grnt         (wbarb_grnt),
      .wb_req             (wb_req),
      .wb_freg_data       (wb_freg_data),
      .wb_ereg_data       (wb_ereg_data),
      .wb_ereg            (wb_ereg),
      .wb_vreg            (wb_vreg),
      .wb_iid             (wb_iid),
      .wb_cmplt           (wb_cmplt),
      .wb_cmplt_iid       (wb_cmplt_iid),
      .cp0_fflags_clr     (cp0_fflags_clr),
      .wb_fflags          (wb_fflags),
      .wb_cnt             (wb_cnt)
   );

   initial forever_cpuclk = 1'b0;
   always #5 forever_cpuclk = ~forever_cpuclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: an in-order queue of pending results
   typedef struct {
      logic [DATA_W-1:0] data;
      logic [4:0]        flags;
      logic [4:0]        ereg;
      logic [6:0]        vreg;
      logic [6:0]        iid;
   } ent_t;

   ent_t       m_q[$];
   logic       m_cmplt;
   logic [6:0] m_cmplt_iid;
   logic [4:0] m_fflags;

   task automatic model_reset();
      m_q.delete();
      m_cmplt     = 1'b0;
      m_cmplt_iid = '0;
      m_fflags    = '0;
   endtask

   // Advances the model by one clock using the inputs currently presented.
   task automatic model_step();
      bit   full, pending, accept, retire;
      ent_t head, nw;
      full    = (m_q.size() == DEPTH);
      pending = (m_q.size() != 0);
      accept  = vfdsu_wb_vld && !full && !rtu_yy_xx_flush;
      retire  = pending && wbarb_grnt && !rtu_yy_xx_flush;
      head    = pending ? m_q[0] : '{default: '0};
      m_cmplt = retire;
      if (retire) m_cmplt_iid = head.iid;
      if (cp0_fflags_clr) m_fflags = retire ? head.flags : 5'h0;
      else if (retire)    m_fflags = m_fflags | head.flags;
      if (rtu_yy_xx_flush) begin
         m_q.delete();
      end else begin
         if (retire) void'(m_q.pop_front());
         if (accept) begin
            nw.data  = vfdsu_wb_freg_data;
            nw.flags = vfdsu_wb_ereg_data;
            nw.ereg  = vfdsu_wb_ereg;
            nw.vreg  = vfdsu_wb_vreg;
            nw.iid   = vfdsu_wb_iid;
            m_q.push_back(nw);
         end
      end
   endtask

   task automatic compare_model();
      check("model_cnt",       64'(wb_cnt),         64'(m_q.size()));
      check("model_req",       64'(wb_req),         64'(m_q.size() != 0));
      check("model_stall",     64'(wb_vfdsu_stall), 64'(m_q.size() == DEPTH));
      check("model_cmplt",     64'(wb_cmplt),       64'(m_cmplt));
      check("model_cmplt_iid", 64'(wb_cmplt_iid),   64'(m_cmplt_iid));
      check("model_fflags",    64'(wb_fflags),      64'(m_fflags));
      if (m_q.size() != 0) begin
         check("model_head_data",  wb_freg_data,       m_q[0].data);
         check("model_head_flags", 64'(wb_ereg_data),  64'(m_q[0].flags));
         check("model_head_ereg",  64'(wb_ereg),       64'(m_q[0].ereg));
         check("model_head_vreg",  64'(wb_vreg),       64'(m_q[0].vreg));
         check("model_head_iid",   64'(wb_iid),        64'(m_q[0].iid));
      end
   endtask

   task automatic drive(input logic vld, input logic [6:0] iid, input logic [4:0] flags,
                        input logic [63:0] data, input logic grnt, input logic flush,
                        input logic clr);
      vfdsu_wb_vld       = vld;
      vfdsu_wb_iid       = iid;
      vfdsu_wb_ereg_data = flags;
      vfdsu_wb_freg_data = data;
      vfdsu_wb_ereg      = iid[4:0] ^ 5'h15;
      vfdsu_wb_vreg      = iid ^ 7'h2A;
      wbarb_grnt         = grnt;
      rtu_yy_xx_flush    = flush;
      cp0_fflags_clr     = clr;
   endtask

   // One clock: model advances on the same inputs, outputs sampled 1ns after the edge.
   task automatic tick();
      model_step();
      @(posedge forever_cpuclk);
      #1;
      compare_model();
   endtask

   // ---------------- directed table: three pushes against a held-off arbiter
   typedef struct {
      logic       vld;
      logic [6:0] iid;
      logic       grnt;
      logic       e_req;
      logic [2:0] e_cnt;
      logic       e_stall;
      logic       e_cmplt;
      logic [6:0] e_cmplt_iid;
      logic [4:0] e_fflags;
      logic [6:0] e_head_iid;
   } vec_t;

   vec_t vecs[7];

   initial begin
      // vld iid grnt | req cnt stall cmplt cmplt_iid fflags head
      vecs[0] = '{1'b1, 7'd1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 7'd0, 5'h00, 7'd1};
      vecs[1] = '{1'b1, 7'd2, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 7'd0, 5'h00, 7'd1};
      vecs[2] = '{1'b1, 7'd3, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 7'd0, 5'h00, 7'd1};
      vecs[3] = '{1'b1, 7'd3, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 7'd1, 5'h01, 7'd2};
      vecs[4] = '{1'b1, 7'd3, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 7'd2, 5'h03, 7'd3};
      vecs[5] = '{1'b0, 7'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 7'd3, 5'h03, 7'd0};
      vecs[6] = '{1'b0, 7'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 7'd3, 5'h03, 7'd0};

      cpurst_b = 1'b0;
      drive(1'b0, 7'd0, 5'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      model_reset();
      #12;
      check("rst_req",   64'(wb_req),         64'd0);
      check("rst_cnt",   64'(wb_cnt),         64'd0);
      check("rst_stall", 64'(wb_vfdsu_stall), 64'd0);
      check("rst_cmplt", 64'(wb_cmplt),       64'd0);
      check("rst_ciid",  64'(wb_cmplt_iid),   64'd0);
      check("rst_ffl",   64'(wb_fflags),      64'd0);
      check("rst_data",  wb_freg_data,        64'd0);
      check("rst_iid",   64'(wb_iid),         64'd0);
      cpurst_b = 1'b1;
      @(posedge forever_cpuclk);
      #1;

      // Table: order 1,2,3 preserved; iid 3 accepted the cycle after the first pop.
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].vld, vecs[i].iid, vecs[i].iid[4:0], 64'(vecs[i].iid) * 64'h1111,
               vecs[i].grnt, 1'b0, 1'b0);
         tick();
         check($sformatf("tbl%0d_req", i),   64'(wb_req),         64'(vecs[i].e_req));
         check($sformatf("tbl%0d_cnt", i),   64'(wb_cnt),         64'(vecs[i].e_cnt));
         check($sformatf("tbl%0d_stall", i), 64'(wb_vfdsu_stall), 64'(vecs[i].e_stall));
         check($sformatf("tbl%0d_cmplt", i), 64'(wb_cmplt),       64'(vecs[i].e_cmplt));
         check($sformatf("tbl%0d_ciid", i),  64'(wb_cmplt_iid),   64'(vecs[i].e_cmplt_iid));
         check($sformatf("tbl%0d_ffl", i),   64'(wb_fflags),      64'(vecs[i].e_fflags));
         if (vecs[i].e_req)
            check($sformatf("tbl%0d_head", i), 64'(wb_iid), 64'(vecs[i].e_head_iid));
      end

      // Single push with grant tied high: req at N+1, completion at N+2.
      drive(1'b0, 7'd0, 5'h0, 64'h0, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b1, 7'd5, 5'h01, 64'h3FF0000000000000, 1'b1, 1'b0, 1'b0);
      tick();
      check("t1_req",   64'(wb_req),   64'd1);
      check("t1_iid",   64'(wb_iid),   64'd5);
      check("t1_data",  wb_freg_data,  64'h3FF0000000000000);
      check("t1_cmplt0",64'(wb_cmplt), 64'd0);
      drive(1'b0, 7'd0, 5'h0, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();
      check("t1_cmplt", 64'(wb_cmplt),     64'd1);
      check("t1_ciid",  64'(wb_cmplt_iid), 64'd5);
      check("t1_ffl",   64'(wb_fflags),    64'h01);
      check("t1_req0",  64'(wb_req),       64'd0);
      tick();
      check("t1_pulse", 64'(wb_cmplt),     64'd0);

      // Steady state at one entry: push+pop each cycle, pointers wrap repeatedly.
      drive(1'b1, 7'd6, 5'h0, 64'h66, 1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 7'(7 + k), 5'h0, 64'(k) << 8, 1'b1, 1'b0, 1'b0);
         tick();
         check($sformatf("t3_cnt%0d", k),  64'(wb_cnt),       64'd1);
         check($sformatf("t3_head%0d", k), 64'(wb_iid),       64'(7 + k));
         check($sformatf("t3_ciid%0d", k), 64'(wb_cmplt_iid), 64'(6 + k));
      end
      drive(1'b0, 7'd0, 5'h0, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();
      check("t3_drain", 64'(wb_cnt), 64'd0);

      // Flush with two entries and a concurrent push+grant.
      drive(1'b1, 7'd20, 5'h0, 64'hA, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 7'd21, 5'h0, 64'hB, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 7'd0, 5'h0, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();
      check("t4_cmplt_prior", 64'(wb_cmplt), 64'd1);
      drive(1'b1, 7'd22, 5'h0, 64'hC, 1'b1, 1'b0, 1'b0);
      tick();
      check("t4_cnt_pre", 64'(wb_cnt), 64'd1);
      drive(1'b1, 7'd23, 5'h0, 64'hD, 1'b0, 1'b0, 1'b0);
      tick();
      check("t4_full", 64'(wb_cnt), 64'd2);
      drive(1'b1, 7'd24, 5'h1F, 64'hE, 1'b1, 1'b1, 1'b0);
      tick();
      check("t4_cnt",   64'(wb_cnt),         64'd0);
      check("t4_req",   64'(wb_req),         64'd0);
      check("t4_stall", 64'(wb_vfdsu_stall), 64'd0);
      check("t4_cmplt", 64'(wb_cmplt),       64'd0);

      // Sticky flags accumulate, then clear coincident with a pop keeps only that pop.
      drive(1'b0, 7'd0, 5'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 7'd30, 5'h04, 64'h1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 7'd31, 5'h10, 64'h2, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 7'd0, 5'h0, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();
      check("t5_ffl14", 64'(wb_fflags), 64'h14);
      drive(1'b1, 7'd32, 5'h02, 64'h3, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 7'd0, 5'h0, 64'h0, 1'b1, 1'b0, 1'b1);
      tick();
      check("t5_ffl02", 64'(wb_fflags), 64'h02);

      // Asynchronous reset with two entries buffered.
      drive(1'b1, 7'd40, 5'h08, 64'h4, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 7'd41, 5'h08, 64'h5, 1'b0, 1'b0, 1'b0);
      tick();
      check("t6_pre_cnt", 64'(wb_cnt), 64'd2);
      drive(1'b0, 7'd0, 5'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      #3;
      cpurst_b = 1'b0;
      #1;
      model_reset();
      check("t6_req",   64'(wb_req),         64'd0);
      check("t6_cnt",   64'(wb_cnt),         64'd0);
      check("t6_ffl",   64'(wb_fflags),      64'd0);
      check("t6_stall", 64'(wb_vfdsu_stall), 64'd0);
      #2;
      cpurst_b = 1'b1;

      // Randomized traffic against the queue model.
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
               7'($urandom),
               5'($urandom),
               {$urandom, $urandom},
               ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
               ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
